// File: rtl/lock_pkg.sv
// Shared state encoding and sizing helpers for the combination-lock access controller.
package lock_pkg;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StEntry   = 3'd1,
      StEval    = 3'd2,
      StOpen    = 3'd3,
      StProg    = 3'd4,
      StLockout = 3'd5
   } lock_state_e;

   // Minimum of 1 so single-value counters still get a real bit.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 1;
      while ((32'd1 << r) < v) r = r + 1;
      return r;
   endfunction

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter that saturates at zero; zero_o flags an expired interval.
module lock_timer #(
   parameter int unsigned Width = 5
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [Width-1:0] value_i,
   input  logic             en_i,
   output logic             zero_o
);

   logic [Width-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = value_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - Width'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lock_access_ctrl.sv
// Serial combination-lock sequencer: code entry, timed unlock window, failure lockout
// and in-window re-programming of the (volatile) code register.
module lock_access_ctrl
   import lock_pkg::*;
#(
   parameter int unsigned          CODE_LEN     = 4,
   parameter logic [CODE_LEN-1:0]  DEFAULT_CODE = 4'b0100,
   parameter int unsigned          MAX_FAIL     = 3,
   parameter int unsigned          UNLOCK_CYC   = 8,
   parameter int unsigned          LOCKOUT_CYC  = 16,
   parameter int unsigned          TIMEOUT_CYC  = 10
) (
   input  logic                             CLK,
   input  logic                             R,
   input  logic                             IN_VALID,
   input  logic                             IN,
   input  logic                             PROG_REQ,
   output logic                             Unlock,
   output logic                             Alarm,
   output logic                             Err,
   output logic                             Prog_done,
   output logic [clog2(MAX_FAIL+1)-1:0]     Fail_cnt
);

   localparam int unsigned TW = clog2(max3(UNLOCK_CYC, LOCKOUT_CYC, TIMEOUT_CYC) + 1);
   localparam int unsigned BW = clog2(CODE_LEN);
   localparam int unsigned FW = clog2(MAX_FAIL + 1);

   // Timer is loaded with N-1 so the state lasts exactly N cycles.
   localparam logic [TW-1:0] TUnlock  = TW'(UNLOCK_CYC - 1);
   localparam logic [TW-1:0] TLockout = TW'(LOCKOUT_CYC - 1);
   localparam logic [TW-1:0] TTimeout = TW'(TIMEOUT_CYC - 1);
   localparam logic [BW-1:0] LastBit  = BW'(CODE_LEN - 1);

   lock_state_e         state_q, state_d;
   logic [CODE_LEN-1:0] shift_q, shift_d;
   logic [CODE_LEN-1:0] code_q, code_d;
   logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [FW-1:0]       fail_q, fail_d;
   logic                err_pend_q, err_pend_d;
   logic                prog_pend_q, prog_pend_d;
   logic                unlock_q, alarm_q, err_q, prog_done_q;

   logic                tmr_load, tmr_en, tmr_zero;
   logic [TW-1:0]       tmr_val;

   lock_timer #(
      .Width (TW)
   ) u_timer (
      .clk_i   (CLK),
      .rst_ni  (R),
      .load_i  (tmr_load),
      .value_i (tmr_val),
      .en_i    (tmr_en),
      .zero_o  (tmr_zero)
   );

   assign tmr_en = (state_q != StIdle);

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      code_d      = code_q;
      bit_cnt_d   = bit_cnt_q;
      fail_d      = fail_q;
      err_pend_d  = 1'b0;
      prog_pend_d = 1'b0;
      tmr_load    = 1'b0;
      tmr_val     = '0;

      case (state_q)
         StIdle: begin
            if (IN_VALID) begin
               shift_d   = {shift_q[CODE_LEN-2:0], IN};
               bit_cnt_d = BW'(1);
               tmr_load  = 1'b1;
               tmr_val   = TTimeout;
               state_d   = StEntry;
            end
         end
         StEntry, StProg: begin
            if (IN_VALID) begin
               shift_d  = {shift_q[CODE_LEN-2:0], IN};
               tmr_load = 1'b1;
               tmr_val  = TTimeout;
               if (bit_cnt_q == LastBit) begin
                  bit_cnt_d = '0;
                  if (state_q == StProg) begin
                     code_d      = shift_d;
                     prog_pend_d = 1'b1;
                     state_d     = StIdle;
                  end else begin
                     state_d = StEval;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end else if (tmr_zero) begin
               bit_cnt_d  = '0;
               err_pend_d = 1'b1;
               state_d    = StIdle;
            end
         end
         StEval: begin
            if (shift_q == code_q) begin
               fail_d   = '0;
               tmr_load = 1'b1;
               tmr_val  = TUnlock;
               state_d  = StOpen;
            end else begin
               fail_d     = fail_q + FW'(1);
               err_pend_d = 1'b1;
               if (fail_d == FW'(MAX_FAIL)) begin
                  tmr_load = 1'b1;
                  tmr_val  = TLockout;
                  state_d  = StLockout;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StOpen: begin
            if (PROG_REQ) begin
               tmr_load = 1'b1;
               tmr_val  = TTimeout;
               state_d  = StProg;
            end else if (tmr_zero) begin
               state_d = StIdle;
            end
         end
         StLockout: begin
            if (tmr_zero) begin
               fail_d  = '0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output stage lags the state/event by one edge so every output is a plain flop.
   always_ff @(posedge CLK or negedge R) begin
      if (!R) begin
         state_q     <= StIdle;
         shift_q     <= '0;
         code_q      <= DEFAULT_CODE;
         bit_cnt_q   <= '0;
         fail_q      <= '0;
         err_pend_q  <= 1'b0;
         prog_pend_q <= 1'b0;
         unlock_q    <= 1'b0;
         alarm_q     <= 1'b0;
         err_q       <= 1'b0;
         prog_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         code_q      <= code_d;
         bit_cnt_q   <= bit_cnt_d;
         fail_q      <= fail_d;
         err_pend_q  <= err_pend_d;
         prog_pend_q <= prog_pend_d;
         unlock_q    <= (state_q == StOpen);
         alarm_q     <= (state_q == StLockout);
         err_q       <= err_pend_q;
         prog_done_q <= prog_pend_q;
      end
   end

   assign Unlock    = unlock_q;
   assign Alarm     = alarm_q;
   assign Err       = err_q;
   assign Prog_done = prog_done_q;
   assign Fail_cnt  = fail_q;

endmodule
